// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and frame constants for the SPI register controller
package spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, ERR} spi_state_t;

  localparam int SPI_RW_BIT = 7;
  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with one-clk rise/fall event outputs
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   warm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
      warm_q <= {warm_q[STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the chain has flushed its reset value, so a pin
  // already away from its idle level at reset release does not look like an edge.
  assign rise_o = warm_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = warm_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - oversampled SPI mode-0 slave driving a small register file
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int         NREGS       = 4,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sck,
  input  logic               sdi,
  input  logic               nss,
  output logic               sdo,
  output logic [NREGS*8-1:0] regs,
  output logic               wr_strobe,
  output logic [AW-1:0]      wr_addr,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [7:0] NREGS_W = 8'(NREGS);

  logic sck_rise, sck_fall, nss_rise, nss_fall;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic sdi_s;

  spi_state_t state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-2:0]   rx_q, rx_d;
  logic [SPI_BYTE_W-1:0]   tx_q, tx_d;
  logic [SPI_BYTE_W-1:0]   rx_next;
  logic                    rw_q, rw_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic                    frame_err_q, frame_err_d;
  logic                    reg_we;
  logic [SPI_BYTE_W-1:0]   regs_q [NREGS];

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_nss_sync (
    .clk(clk), .rst(rst), .din_i(nss), .rise_o(nss_rise), .fall_o(nss_fall)
  );

  // Same depth as the sck chain so sdi is sampled at the same instant as the rise.
  always_ff @(posedge clk) begin
    if (rst) sdi_sync_q <= '0;
    else     sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
  end
  assign sdi_s   = sdi_sync_q[SYNC_STAGES-1];
  assign rx_next = {rx_q, sdi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    reg_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (nss_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      CMD: begin
        if (sck_rise) begin
          rx_d      = rx_next[SPI_BYTE_W-2:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ({1'b0, rx_next[SPI_RW_BIT-1:0]} >= NREGS_W) begin
              state_d     = ERR;
              frame_err_d = 1'b1;
            end else begin
              state_d = DATA;
              rw_d    = rx_next[SPI_RW_BIT];
              addr_d  = rx_next[AW-1:0];
              if (rx_next[SPI_RW_BIT]) tx_d = regs_q[rx_next[AW-1:0]];
            end
          end
        end
      end
      DATA: begin
        if (rw_q) begin
          // The fall closing the command byte arrives with bit_cnt==0 and must not shift.
          if (sck_fall && bit_cnt_q != 3'd0) tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = DONE;
          end
        end else if (sck_rise) begin
          rx_d      = rx_next[SPI_BYTE_W-2:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d     = DONE;
            reg_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end
        end
      end
      default: ;
    endcase

    if (nss_rise && state_q != IDLE) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      reg_we      = 1'b0;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = (state_q == CMD) || (state_q == DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else if (reg_we) begin
      regs_q[addr_q] <= rx_next;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign sdo       = (state_q == DATA) && rw_q && tx_q[SPI_BYTE_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench: frame-level register model against spi_reg_ctrl
module tb_spi_reg_ctrl;

  localparam int NREGS = 4;
  localparam int H     = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        nss = 1'b1;
  logic        sdo;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [1:0]  wr_addr;
  logic        frame_err;
  logic        busy;

  spi_reg_ctrl #(.NREGS(NREGS), .RESET_VAL(8'h00), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .nss(nss), .sdo(sdo),
    .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ref_regs [NREGS];
  wr_t        exp_wr [$];
  int         exp_err [$];
  logic [7:0] exp_rd [$];
  logic [7:0] obs_rd [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      wr_t        e;
      logic [7:0] o;
      @(negedge clk);
      if (!rst) begin
        if (wr_strobe) begin
          check("wr_strobe_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(regs[32'(e.addr)*8 +: 8]), 32'(e.data));
            check("wr_without_err", 32'(frame_err), 32'd0);
          end
        end
        if (frame_err) begin
          check("frame_err_expected", 32'(exp_err.size() > 0), 32'd1);
          if (exp_err.size() > 0) void'(exp_err.pop_front());
        end
        while (obs_rd.size() > 0) begin
          o = obs_rd.pop_front();
          check("sdo_byte_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) check("sdo_byte", 32'(o), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      sdi = b[7-i];
      repeat (H) @(negedge clk);
      sck = 1'b1;
      got[7-i] = sdo;
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic check_after_frame();
    check("drain", 32'(exp_wr.size() + exp_err.size() + exp_rd.size()), 32'd0);
    check("regs", regs, {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]});
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // nbits = total SCK cycles clocked before nss returns high.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nbits);
    logic [7:0] bytes [3];
    logic [7:0] got;
    logic [7:0] rdv;
    logic [6:0] a;
    logic       rd_ok;
    wr_t        w;
    int         nb;
    bytes = '{b0, b1, b2};
    a     = b0[6:0];
    rd_ok = 1'b0;
    rdv   = 8'h00;
    if (nbits < 8)                 exp_err.push_back(1);
    else if (int'(a) >= NREGS)     exp_err.push_back(1);
    else if (nbits < 16)           exp_err.push_back(1);
    else if (!b0[7]) begin
      ref_regs[a[1:0]] = b1;
      w.addr = a[1:0];
      w.data = b1;
      exp_wr.push_back(w);
    end else begin
      rd_ok = 1'b1;
      rdv   = ref_regs[a[1:0]];
    end
    for (int k = 0; k < 3; k++)
      if (nbits >= 8*(k+1)) exp_rd.push_back((k == 1 && rd_ok) ? rdv : 8'h00);

    nss = 1'b0;
    repeat (H) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nb = nbits - 8*k;
      if (nb > 8) nb = 8;
      if (nb > 0) begin
        spi_bits(bytes[k], nb, got);
        if (nb == 8) obs_rd.push_back(got);
      end
    end
    repeat (H) @(negedge clk);
    nss = 1'b1;
    sdi = 1'b0;
    repeat (12) @(negedge clk);
    check_after_frame();
  endtask

  initial begin
    logic [7:0] got;
    logic [6:0] a;
    int         sel, nbits;

    for (int i = 0; i < NREGS; i++) ref_regs[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_regs", regs, 32'h0);
    check("reset_sdo", 32'(sdo), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobes", 32'({wr_strobe, frame_err}), 32'd0);
    repeat (8) @(negedge clk);

    run_frame(8'h02, 8'hA5, 8'h00, 16);
    run_frame(8'h01, 8'h3C, 8'h00, 16);
    run_frame(8'h81, 8'h00, 8'h00, 16);
    run_frame(8'h10, 8'hFF, 8'h00, 16);
    run_frame(8'h00, 8'h77, 8'h00, 13);
    run_frame(8'h00, 8'h11, 8'h00, 16);
    run_frame(8'h01, 8'h22, 8'h33, 24);
    run_frame(8'h83, 8'h00, 8'h00, 0);

    for (int r = 0; r < 24; r++) begin
      a   = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(4, 127)) : 7'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 5));
      nbits = (sel == 0) ? int'($urandom_range(0, 15)) : (sel == 1) ? 24 : 16;
      run_frame({1'($urandom_range(0, 1)), a}, 8'($urandom), 8'($urandom), nbits);
    end

    // Reset in the middle of a frame while nss stays low.
    nss = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(8'h02, 4, got);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 8'h00;
    spi_bits(8'h2F, 8, got);
    spi_bits(8'hFF, 8, got);
    repeat (H) @(negedge clk);
    nss = 1'b1;
    repeat (12) @(negedge clk);
    check_after_frame();
    run_frame(8'h03, 8'h5A, 8'h00, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
